// File: rtl/axis_pipe_pkg.sv
// Shared types and helpers for the AXI-Stream elastic pipeline.
// Holds the default beat layout and the occupancy width helper.
package axis_pipe_pkg;

  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_USER_BITS  = 1;
  localparam int DEF_STAGES     = 2;

  typedef struct packed {
    logic [DEF_DATA_BYTES*8-1:0] data;
    logic [DEF_DATA_BYTES-1:0]   keep;
    logic [DEF_USER_BITS-1:0]    user;
    logic                        last;
  } beat_t;

  // Room for every stage plus the optional skid entry plus zero.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// One-entry skid buffer; input ready is the registered "skid empty".
// Ports: s_* beat in (flat vector), m_* beat out, clk_i/rst_i (async high).
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] skid_q;
  logic             skid_vld_q;
  logic             skid_vld_d;

  // Ready only depends on local state, so no combinational path
  // from m_ready_i reaches s_ready_o.
  assign s_ready_o = ~skid_vld_q & ~rst_i;
  assign m_valid_o = skid_vld_q | s_valid_i;
  assign m_data_o  = skid_vld_q ? skid_q : s_data_i;

  always_comb begin
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (m_ready_i) skid_vld_d = 1'b0;
    end else if (s_valid_i && !m_ready_i) begin
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) skid_vld_q <= 1'b0;
    else       skid_vld_q <= skid_vld_d;
  end

  always_ff @(posedge clk_i) begin
    if (!skid_vld_q && s_valid_i && !m_ready_i)
      skid_q <= s_data_i;
  end

endmodule

// File: rtl/axis_elastic_pipe.sv
// AXI-Stream register pipeline with per-stage backpressure (bubbles collapse).
// Ports: axis_s_* in, axis_m_* out, occupancy_o beats held.
// AXIS_PIPE_SKID_EN adds a 1-entry skid with registered input ready.
module axis_elastic_pipe
  import axis_pipe_pkg::*;
#(
  parameter int DATA_BYTES      = DEF_DATA_BYTES,
  parameter int USER_BITS       = DEF_USER_BITS,
  parameter int PIPELINE_STAGES = DEF_STAGES,
  parameter int OCC_BITS        = occ_width(PIPELINE_STAGES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_BYTES*8-1:0] axis_s_data_i,
  input  logic [DATA_BYTES-1:0]   axis_s_keep_i,
  input  logic [USER_BITS-1:0]    axis_s_user_i,
  input  logic                    axis_s_last_i,
  input  logic                    axis_s_valid_i,
  output logic                    axis_s_ready_o,
  output logic [DATA_BYTES*8-1:0] axis_m_data_o,
  output logic [DATA_BYTES-1:0]   axis_m_keep_o,
  output logic [USER_BITS-1:0]    axis_m_user_o,
  output logic                    axis_m_last_o,
  output logic                    axis_m_valid_o,
  input  logic                    axis_m_ready_i,
  output logic [OCC_BITS-1:0]     occupancy_o
);

  localparam int S  = PIPELINE_STAGES;
  localparam int BW = DATA_BYTES*8 + DATA_BYTES + USER_BITS + 1;

  typedef struct packed {
    logic [DATA_BYTES*8-1:0] data;
    logic [DATA_BYTES-1:0]   keep;
    logic [USER_BITS-1:0]    user;
    logic                    last;
  } pbeat_t;

  pbeat_t       s_beat;
  pbeat_t       in_beat;
  logic         in_valid;
  logic [S-1:0] valid_q;
  logic [S:0]   adv;
  pbeat_t       out_beat;

  assign s_beat.data = axis_s_data_i;
  assign s_beat.keep = axis_s_keep_i;
  assign s_beat.user = axis_s_user_i;
  assign s_beat.last = axis_s_last_i;

`ifdef AXIS_PIPE_SKID_EN
  logic [BW-1:0] in_vec;

  axis_skid_buf #(
    .WIDTH(BW)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .s_data_i (BW'(s_beat)),
    .s_valid_i(axis_s_valid_i),
    .s_ready_o(axis_s_ready_o),
    .m_data_o (in_vec),
    .m_valid_o(in_valid),
    .m_ready_i(adv[0])
  );

  assign in_beat = pbeat_t'(in_vec);
`else
  assign in_beat        = s_beat;
  assign in_valid       = axis_s_valid_i;
  assign axis_s_ready_o = adv[0] & ~rst_i;
`endif

  // A stage may load if it is empty or its successor is loading.
  always_comb begin
    adv    = '0;
    adv[S] = axis_m_ready_i;
    for (int k = S - 1; k >= 0; k--)
      adv[k] = ~valid_q[k] | adv[k+1];
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic   v_q;
    pbeat_t b_q;
    logic   v_in;
    pbeat_t b_in;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign b_in = in_beat;
    end else begin : g_body
      assign v_in = g_stage[k-1].v_q;
      assign b_in = g_stage[k-1].b_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       v_q <= 1'b0;
      else if (adv[k]) v_q <= v_in;
    end

    always_ff @(posedge clk_i) begin
      if (adv[k]) b_q <= b_in;
    end

    assign valid_q[k] = v_q;
  end

  assign out_beat       = g_stage[S-1].b_q;
  assign axis_m_data_o  = out_beat.data;
  assign axis_m_keep_o  = out_beat.keep;
  assign axis_m_user_o  = out_beat.user;
  assign axis_m_last_o  = out_beat.last;
  assign axis_m_valid_o = valid_q[S-1];

  logic                push;
  logic                pop;
  logic [OCC_BITS-1:0] occ_q;
  logic [OCC_BITS-1:0] occ_d;

  assign push = axis_s_valid_i & axis_s_ready_o;
  assign pop  = axis_m_valid_o & axis_m_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_axis_elastic_pipe.sv
// Directed self-checking bench for axis_elastic_pipe.
// Build with AXIS_PIPE_SKID_EN to exercise the skid variant (3 stages).
module tb_axis_elastic_pipe;

`ifdef AXIS_PIPE_SKID_EN
  localparam int STG = 3;
`else
  localparam int STG = 2;
`endif
  localparam int OB = $clog2(STG + 2);

  logic          clk;
  logic          rst;
  logic [31:0]   s_data;
  logic [3:0]    s_keep;
  logic [0:0]    s_user;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;
  logic [0:0]    m_user;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [OB-1:0] occ;

  int checks = 0;
  int fails  = 0;

  axis_elastic_pipe #(
    .DATA_BYTES     (4),
    .USER_BITS      (1),
    .PIPELINE_STAGES(STG),
    .OCC_BITS       (OB)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .axis_s_data_i (s_data),
    .axis_s_keep_i (s_keep),
    .axis_s_user_i (s_user),
    .axis_s_last_i (s_last),
    .axis_s_valid_i(s_valid),
    .axis_s_ready_o(s_ready),
    .axis_m_data_o (m_data),
    .axis_m_keep_o (m_keep),
    .axis_m_user_o (m_user),
    .axis_m_last_o (m_last),
    .axis_m_valid_o(m_valid),
    .axis_m_ready_i(m_ready),
    .occupancy_o   (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic l, input logic [3:0] k,
                       input logic u);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    s_keep  = k;
    s_user  = u;
  endtask

  logic [31:0] exp_q[$];
  int          nacc;
  int          npop;
  logic        pushed;
  logic        popped;
  logic [31:0] want;

  initial begin
    rst     = 1'b1;
    m_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_occ", occ, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_sready", s_ready, 1);

`ifndef AXIS_PIPE_SKID_EN
    // Streaming 0x01..0x10 with ready held high.
    m_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c < 16)
        drive(1, 32'(c + 1), (c + 1 == 16), 4'hf, 1'((c + 1) & 1));
      else
        drive(0, 0, 0, 0, 0);
      #1;
      chk("str_sready", s_ready, 1);
      if (c < 2) begin
        chk("str_lat", m_valid, 0);
      end else begin
        chk("str_valid", m_valid, 1);
        chk("str_data", m_data, 64'(c - 1));
        chk("str_last", m_last, 64'(c - 1 == 16));
        chk("str_user", m_user, 64'((c - 1) & 1));
        chk("str_keep", m_keep, 4'hf);
      end
      if (c == 5) chk("str_occ", occ, 2);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("str_drain_valid", m_valid, 0);
    chk("str_drain_occ", occ, 0);

    // Bubble collapse: A, gap, B with output stalled.
    m_ready = 1'b0;
    tick();
    drive(1, 32'hAAAA0001, 0, 4'hf, 0);
    #1;
    chk("bub_sready0", s_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("bub_occ1", occ, 1);
    chk("bub_mvalid0", m_valid, 0);
    chk("bub_sready1", s_ready, 1);
    tick();
    drive(1, 32'hBBBB0002, 1, 4'hf, 1);
    #1;
    chk("bub_mvalid1", m_valid, 1);
    chk("bub_data_a", m_data, 32'hAAAA0001);
    chk("bub_occ1b", occ, 1);
    chk("bub_sready2", s_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("bub_occ2", occ, 2);
    chk("bub_full_sready", s_ready, 0);
    chk("bub_hold_a", m_data, 32'hAAAA0001);
    tick();
    m_ready = 1'b1;
    #1;
    chk("bub_out_a", m_data, 32'hAAAA0001);
    chk("bub_rdy_comb", s_ready, 1);
    tick();
    chk("bub_out_b_v", m_valid, 1);
    chk("bub_out_b", m_data, 32'hBBBB0002);
    chk("bub_out_b_last", m_last, 1);
    tick();
    chk("bub_empty_v", m_valid, 0);
    chk("bub_empty_occ", occ, 0);

    // Fill, then simultaneous push and pop on the full pipe.
    m_ready = 1'b0;
    drive(1, 32'h11, 0, 4'hf, 0);
    tick();
    drive(1, 32'h22, 1, 4'h3, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("full_occ", occ, 2);
    chk("full_sready", s_ready, 0);
    drive(1, 32'h33, 0, 4'hf, 0);
    m_ready = 1'b1;
    #1;
    chk("pp_sready", s_ready, 1);
    chk("pp_data_x", m_data, 32'h11);
    tick();
    m_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("pp_occ", occ, 2);
    chk("pp_data_y", m_data, 32'h22);

    // Output must hold stable while stalled.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stb_valid", m_valid, 1);
      chk("stb_data", m_data, 32'h22);
      chk("stb_keep", m_keep, 4'h3);
      chk("stb_user", m_user, 1);
      chk("stb_last", m_last, 1);
    end

    // Asynchronous reset between edges with two beats held.
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_mvalid", m_valid, 0);
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_sready", s_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rel_sready", s_ready, 1);
    tick();
    m_ready = 1'b1;
    drive(1, 32'h44, 1, 4'hf, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rr_lat", m_valid, 0);
    tick();
    chk("rr_first_v", m_valid, 1);
    chk("rr_first_d", m_data, 32'h44);
`else
    // Stall the output and keep offering beats: 3 stages + skid fill.
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1, 32'(nacc), 0, 4'hf, 0);
      #1;
      if (s_ready) begin
        exp_q.push_back(32'(nacc));
        nacc++;
      end
    end
    chk("sk_nacc", 64'(nacc), 4);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("sk_occ", occ, 4);
    chk("sk_sready", s_ready, 0);

    // Random-ready scoreboard over 1000 output beats.
    npop   = 0;
    pushed = 1'b0;
    for (int cyc = 0; cyc < 20000 && npop < 1000; cyc++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      if (!s_valid || pushed)
        s_valid = (nacc < 1100) && ($urandom_range(0, 3) != 0);
      s_data = 32'(nacc);
      s_last = (nacc[3:0] == 4'hf);
      #1;
      chk("sb_occ", occ, 64'(exp_q.size()));
      pushed = s_valid & s_ready;
      popped = m_valid & m_ready;
      if (popped) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("sb_data", m_data, want);
        chk("sb_last", m_last, 64'(want[3:0] == 4'hf));
        npop++;
      end
      if (pushed) begin
        exp_q.push_back(32'(nacc));
        nacc++;
      end
    end
    chk("sb_count", 64'(npop), 1000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
